// File: rtl/stopwatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl_pkg
//  Description : Shared types and constants for the stopwatch front-panel
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SPD_SLOW   = 2'd0,
        SPD_NORMAL = 2'd1,
        SPD_FAST   = 2'd2
    } speed_t;

    typedef enum logic [1:0] {
        LD_RESET = 2'd0,
        LD_ADD   = 2'd1,
        LD_SUB   = 2'd2
    } load_kind_t;

    localparam logic [15:0] T_UP   = 16'h4930;
    localparam logic [15:0] T_DOWN = 16'h1020;

    localparam int c_idx_start = 0;
    localparam int c_idx_reset = 1;
    localparam int c_idx_dir   = 2;
    localparam int c_idx_fast  = 3;
    localparam int c_idx_slow  = 4;
    localparam int c_idx_add   = 5;
    localparam int c_idx_sub   = 6;
    localparam int c_num_btn   = 7;

    function automatic logic [15:0] target_of(input logic rev);
        return rev ? T_DOWN : T_UP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchronizer, counting debouncer and rising-edge pulse
//                for one raw push-button.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_LIMIT = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int                 c_cnt_w    = $clog2(DB_LIMIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_LIMIT - 1);

    logic [1:0]         r_sync_q,  w_sync_d;
    logic               r_level_q, w_level_d;
    logic               r_prev_q;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;

    // The level flips on the DB_LIMIT-th consecutive cycle of disagreement.
    always_comb begin
        w_sync_d  = {r_sync_q[0], i_btn};
        w_level_d = r_level_q;
        w_cnt_d   = '0;
        if (r_sync_q[1] != r_level_q) begin
            if (r_cnt_q == c_cnt_last) begin
                w_level_d = r_sync_q[1];
            end else begin
                w_cnt_d = r_cnt_q + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_q  <= '0;
            r_level_q <= 1'b0;
            r_prev_q  <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_sync_q  <= w_sync_d;
            r_level_q <= w_level_d;
            r_prev_q  <= r_level_q;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign o_rise = r_level_q & ~r_prev_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Front-panel controller: debounced buttons driving a
//                run/pause/load FSM and speed level for the BCD stopwatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DB_LIMIT  = 50000,
    parameter int LOAD_HOLD = 2
) (
    input  logic        clk_in,
    input  logic        RESET_N,
    input  logic        BTN_START,
    input  logic        BTN_RESET,
    input  logic        BTN_DIR,
    input  logic        BTN_FAST,
    input  logic        BTN_SLOW,
    input  logic        BTN_ADD,
    input  logic        BTN_SUB,
    input  logic [15:0] Q,
    output logic        START,
    output logic        RESET,
    output logic        REVERSE,
    output logic        SPEED_UP,
    output logic        SPEED_DOWN,
    output logic        ADD,
    output logic        SUBTRACT,
    output logic [2:0]  STATE,
    output logic        DONE
);
    import stopwatch_ctrl_pkg::*;

    localparam int                  c_hold_w    = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LOAD_HOLD - 1);

    logic [c_num_btn-1:0] w_btn_raw;
    logic [c_num_btn-1:0] w_rise;

    assign w_btn_raw = {BTN_SUB, BTN_ADD, BTN_SLOW, BTN_FAST, BTN_DIR, BTN_RESET, BTN_START};

    generate
        for (genvar i = 0; i < c_num_btn; i++) begin : g_btn
            btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_db (
                .i_clk   (clk_in),
                .i_rst_n (RESET_N),
                .i_btn   (w_btn_raw[i]),
                .o_rise  (w_rise[i])
            );
        end
    endgenerate

    state_t              r_state_q, w_state_d;
    state_t              r_ret_q,   w_ret_d;
    load_kind_t          r_kind_q,  w_kind_d;
    logic [c_hold_w-1:0] r_hold_q,  w_hold_d;
    logic                r_rev_q,   w_rev_d;
    speed_t              r_speed_q, w_speed_d;
    logic                r_start_q, w_start_d;
    logic                r_rst_q,   w_rst_d;
    logic                r_add_q,   w_add_d;
    logic                r_sub_q,   w_sub_d;
    logic                r_done_q,  w_done_d;
    logic                r_up_q,    w_up_d;
    logic                r_down_q,  w_down_d;

    logic w_ev_reset, w_ev_start, w_ev_add, w_ev_sub, w_ev_dir;

    // Fixed priority: reset > start > add > sub > dir; losers are dropped.
    assign w_ev_reset = w_rise[c_idx_reset];
    assign w_ev_start = w_rise[c_idx_start] & ~w_ev_reset;
    assign w_ev_add   = w_rise[c_idx_add]   & ~w_ev_reset & ~w_rise[c_idx_start];
    assign w_ev_sub   = w_rise[c_idx_sub]   & ~w_ev_reset & ~w_rise[c_idx_start] & ~w_rise[c_idx_add];
    assign w_ev_dir   = w_rise[c_idx_dir]   & ~w_ev_reset & ~w_rise[c_idx_start] & ~w_rise[c_idx_add]
                                            & ~w_rise[c_idx_sub];

    always_comb begin
        w_state_d = r_state_q;
        w_ret_d   = r_ret_q;
        w_kind_d  = r_kind_q;
        w_hold_d  = r_hold_q;
        w_rev_d   = r_rev_q;
        if (w_ev_reset) begin
            w_state_d = ST_LOAD;
            w_ret_d   = ST_IDLE;
            w_kind_d  = LD_RESET;
            w_hold_d  = '0;
        end else begin
            case (r_state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (w_ev_start) begin
                        w_state_d = ST_RUN;
                    end else if (w_ev_add || w_ev_sub) begin
                        w_state_d = ST_LOAD;
                        w_ret_d   = r_state_q;
                        w_kind_d  = w_ev_add ? LD_ADD : LD_SUB;
                        w_hold_d  = '0;
                    end else if (w_ev_dir) begin
                        w_rev_d = ~r_rev_q;
                    end
                end
                ST_RUN: begin
                    if (w_ev_start) begin
                        w_state_d = ST_PAUSE;
                    end else if (Q == target_of(r_rev_q)) begin
                        w_state_d = ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (r_hold_q == c_hold_last) begin
                        w_state_d = r_ret_q;
                    end else begin
                        w_hold_d = r_hold_q + c_hold_w'(1);
                    end
                end
                ST_DONE: begin
                    if (w_ev_dir) begin
                        w_rev_d   = ~r_rev_q;
                        w_state_d = ST_IDLE;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end

        w_speed_d = r_speed_q;
        if (w_rise[c_idx_fast] && !w_rise[c_idx_slow] && r_speed_q != SPD_FAST) begin
            w_speed_d = speed_t'(r_speed_q + 2'd1);
        end else if (w_rise[c_idx_slow] && !w_rise[c_idx_fast] && r_speed_q != SPD_SLOW) begin
            w_speed_d = speed_t'(r_speed_q - 2'd1);
        end

        w_start_d = (w_state_d == ST_RUN);
        w_done_d  = (w_state_d == ST_DONE);
        w_rst_d   = (w_state_d == ST_LOAD) && (w_kind_d == LD_RESET);
        w_add_d   = (w_state_d == ST_LOAD) && (w_kind_d == LD_ADD);
        w_sub_d   = (w_state_d == ST_LOAD) && (w_kind_d == LD_SUB);
        w_up_d    = (w_speed_d == SPD_FAST);
        w_down_d  = (w_speed_d == SPD_SLOW);
    end

    always_ff @(posedge clk_in or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state_q <= ST_IDLE;
            r_ret_q   <= ST_IDLE;
            r_kind_q  <= LD_RESET;
            r_hold_q  <= '0;
            r_rev_q   <= 1'b0;
            r_speed_q <= SPD_NORMAL;
            r_start_q <= 1'b0;
            r_rst_q   <= 1'b0;
            r_add_q   <= 1'b0;
            r_sub_q   <= 1'b0;
            r_done_q  <= 1'b0;
            r_up_q    <= 1'b0;
            r_down_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ret_q   <= w_ret_d;
            r_kind_q  <= w_kind_d;
            r_hold_q  <= w_hold_d;
            r_rev_q   <= w_rev_d;
            r_speed_q <= w_speed_d;
            r_start_q <= w_start_d;
            r_rst_q   <= w_rst_d;
            r_add_q   <= w_add_d;
            r_sub_q   <= w_sub_d;
            r_done_q  <= w_done_d;
            r_up_q    <= w_up_d;
            r_down_q  <= w_down_d;
        end
    end

    assign START      = r_start_q;
    assign RESET      = r_rst_q;
    assign REVERSE    = r_rev_q;
    assign SPEED_UP   = r_up_q;
    assign SPEED_DOWN = r_down_q;
    assign ADD        = r_add_q;
    assign SUBTRACT   = r_sub_q;
    assign STATE      = r_state_q;
    assign DONE       = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Scoreboard bench for stopwatch_ctrl (DB_LIMIT=4, LOAD_HOLD=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int DB_LIMIT  = 4;
    localparam int LOAD_HOLD = 2;

    localparam logic [6:0] B_START = 7'h01;
    localparam logic [6:0] B_RESET = 7'h02;
    localparam logic [6:0] B_DIR   = 7'h04;
    localparam logic [6:0] B_FAST  = 7'h08;
    localparam logic [6:0] B_SLOW  = 7'h10;
    localparam logic [6:0] B_ADD   = 7'h20;
    localparam logic [6:0] B_SUB   = 7'h40;

    // Expected-flag bits, in the order they sit in the observed vector.
    localparam logic [7:0] F_DONE  = 8'h80;
    localparam logic [7:0] F_START = 8'h40;
    localparam logic [7:0] F_RST   = 8'h20;
    localparam logic [7:0] F_REV   = 8'h10;
    localparam logic [7:0] F_UP    = 8'h08;
    localparam logic [7:0] F_DN    = 8'h04;
    localparam logic [7:0] F_ADD   = 8'h02;
    localparam logic [7:0] F_SUB   = 8'h01;

    logic        clk_in  = 1'b0;
    logic        rst_n   = 1'b0;
    logic [6:0]  btn     = '0;
    logic [15:0] q       = '0;
    logic        o_start, o_reset, o_rev, o_up, o_down, o_add, o_sub, o_done;
    logic [2:0]  o_state;
    logic [10:0] w_obs;

    always #5 clk_in = ~clk_in;

    stopwatch_ctrl #(.DB_LIMIT(DB_LIMIT), .LOAD_HOLD(LOAD_HOLD)) dut (
        .clk_in     (clk_in),
        .RESET_N    (rst_n),
        .BTN_START  (btn[0]),
        .BTN_RESET  (btn[1]),
        .BTN_DIR    (btn[2]),
        .BTN_FAST   (btn[3]),
        .BTN_SLOW   (btn[4]),
        .BTN_ADD    (btn[5]),
        .BTN_SUB    (btn[6]),
        .Q          (q),
        .START      (o_start),
        .RESET      (o_reset),
        .REVERSE    (o_rev),
        .SPEED_UP   (o_up),
        .SPEED_DOWN (o_down),
        .ADD        (o_add),
        .SUBTRACT   (o_sub),
        .STATE      (o_state),
        .DONE       (o_done)
    );

    assign w_obs = {o_state, o_done, o_start, o_reset, o_rev, o_up, o_down, o_add, o_sub};

    typedef struct {
        string       tag;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [7:0] fl);
        exp_t e;
        e.tag = tag;
        e.val = {st, fl};
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", 11'h000, 11'h7ff);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, w_obs, e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Raw press held until the edge where its event is consumed; returns just after it.
    task automatic press(input logic [6:0] m);
        btn = m;
        cyc(7);
        btn = '0;
    endtask

    task automatic gap();
        cyc(8);
    endtask

    initial begin
        cyc(3);
        push_exp("reset_state", 3'd0, 8'h00);
        pop_cmp();
        rst_n = 1'b1;
        cyc(2);

        // Start held 10 cycles: visible exactly 7 edges after the press begins.
        push_exp("start_lat6", 3'd0, 8'h00);
        push_exp("start_lat7", 3'd1, F_START);
        btn = B_START;
        cyc(6); pop_cmp();
        cyc(1); pop_cmp();
        cyc(3);
        btn = '0;
        gap();

        push_exp("glitch_3cyc", 3'd1, F_START);
        btn = B_START;
        cyc(3);
        btn = '0;
        cyc(12);
        pop_cmp();

        push_exp("run_q_down_target_ign", 3'd1, F_START);
        q = 16'h1020; cyc(1); pop_cmp();
        push_exp("done_entry", 3'd4, F_DONE);
        q = 16'h4930; cyc(1); pop_cmp();
        q = 16'h0000; cyc(2);

        push_exp("done_start_ign", 3'd4, F_DONE);
        press(B_START); pop_cmp(); gap();
        push_exp("done_dir", 3'd0, F_REV);
        press(B_DIR); pop_cmp(); gap();

        push_exp("run_rev", 3'd1, F_START | F_REV);
        press(B_START); pop_cmp(); gap();
        push_exp("rev_up_target_ign", 3'd1, F_START | F_REV);
        q = 16'h4930; cyc(1); pop_cmp();
        push_exp("rev_done", 3'd4, F_DONE | F_REV);
        q = 16'h1020; cyc(1); pop_cmp();
        q = 16'h0000;
        push_exp("done_dir2", 3'd0, 8'h00);
        press(B_DIR); pop_cmp(); gap();

        push_exp("run2", 3'd1, F_START);
        press(B_START); pop_cmp(); gap();
        push_exp("pause", 3'd2, 8'h00);
        press(B_START); pop_cmp(); gap();
        push_exp("pause_q_ign", 3'd2, 8'h00);
        q = 16'h4930; cyc(2); pop_cmp();
        q = 16'h0000; cyc(1);

        push_exp("ld_add_c0", 3'd3, F_ADD);
        push_exp("ld_add_c1", 3'd3, F_ADD);
        push_exp("ld_add_ret", 3'd2, 8'h00);
        press(B_ADD); pop_cmp();
        cyc(1); pop_cmp();
        cyc(1); pop_cmp();
        gap();

        push_exp("run3", 3'd1, F_START);
        press(B_START); pop_cmp(); gap();
        push_exp("run_sub_ign", 3'd1, F_START);
        push_exp("run_sub_ign2", 3'd1, F_START);
        press(B_SUB); pop_cmp();
        cyc(1); pop_cmp();
        gap();

        push_exp("pause2", 3'd2, 8'h00);
        press(B_START); pop_cmp(); gap();

        // Reset press lands one cycle into an ADD load.
        push_exp("ar_add", 3'd3, F_ADD);
        push_exp("ar_rst_c0", 3'd3, F_RST);
        push_exp("ar_rst_c1", 3'd3, F_RST);
        push_exp("ar_idle", 3'd0, 8'h00);
        btn = B_ADD;
        cyc(1);
        btn = B_ADD | B_RESET;
        cyc(6); pop_cmp();
        btn = '0;
        cyc(1); pop_cmp();
        cyc(1); pop_cmp();
        cyc(1); pop_cmp();
        gap();

        push_exp("run4", 3'd1, F_START);
        press(B_START); pop_cmp(); gap();
        push_exp("sr_rst_c0", 3'd3, F_RST);
        push_exp("sr_rst_c1", 3'd3, F_RST);
        push_exp("sr_idle", 3'd0, 8'h00);
        press(B_START | B_RESET); pop_cmp();
        cyc(1); pop_cmp();
        cyc(1); pop_cmp();
        gap();

        for (int i = 0; i < 3; i++) begin
            push_exp($sformatf("fast%0d", i + 1), 3'd0, F_UP);
            press(B_FAST); pop_cmp(); gap();
        end
        push_exp("fast_slow_cancel", 3'd0, F_UP);
        press(B_FAST | B_SLOW); pop_cmp(); gap();
        push_exp("slow1", 3'd0, 8'h00);
        press(B_SLOW); pop_cmp(); gap();
        push_exp("slow2", 3'd0, F_DN);
        press(B_SLOW); pop_cmp(); gap();
        push_exp("slow3", 3'd0, F_DN);
        press(B_SLOW); pop_cmp(); gap();

        push_exp("idle_dir", 3'd0, F_DN | F_REV);
        press(B_DIR); pop_cmp(); gap();
        push_exp("idle_add", 3'd3, F_ADD | F_DN | F_REV);
        press(B_ADD); pop_cmp();

        // Asynchronous reset mid-load clears outputs without a clock edge.
        push_exp("async_rst", 3'd0, 8'h00);
        rst_n = 1'b0;
        #1;
        pop_cmp();

        btn = B_START;
        cyc(2);
        rst_n = 1'b1;
        push_exp("held_thru_rst6", 3'd0, 8'h00);
        push_exp("held_thru_rst7", 3'd1, F_START);
        cyc(6); pop_cmp();
        cyc(1); pop_cmp();
        btn = '0;
        cyc(2);

        check_val("sb_drained", 11'(sb.size()), 11'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
